// File: rtl/sumador_tx.sv
// Bit-serial transmitter for the adder tile: sends {carry, sum} as a framed word
// with start bit, 9 data bits LSB first, even parity and stop bit on a single pin.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | line idle (tx=1), ready follows ena
// START  | start bit (tx=0)
// DATA   | 9 data bits, sum[0] first, carry last
// PARITY | even parity over the 9 data bits
// STOP   | stop bit (tx=1), frame_done in its last cycle
module sumador_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] sum_in,
   input  logic       carry_in,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [8:0]        shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              baud_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign baud_wrap = (baud_q == BAUD_MAX);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = tx_q;

      // With ena low every register keeps its value so the frame resumes in place.
      if (ena) begin
         case (state_q)
            S_IDLE: begin
               if (valid && ready_q) begin
                  shift_d  = {carry_in, sum_in};
                  parity_d = ^{carry_in, sum_in};
                  baud_d   = '0;
                  bit_d    = '0;
                  tx_d     = 1'b0;
                  state_d  = S_START;
               end
            end
            S_START: begin
               if (baud_wrap) begin
                  baud_d  = '0;
                  tx_d    = shift_q[0];
                  state_d = S_DATA;
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_wrap) begin
                  baud_d = '0;
                  if (bit_q == 4'd8) begin
                     bit_d   = '0;
                     tx_d    = parity_q;
                     state_d = S_PARITY;
                  end else begin
                     bit_d   = bit_q + 4'd1;
                     shift_d = {1'b0, shift_q[8:1]};
                     tx_d    = shift_q[1];
                  end
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (baud_wrap) begin
                  baud_d  = '0;
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_wrap) begin
                  baud_d  = '0;
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end
            default: begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end

      // Flag outputs are decoded from the next state so they line up with tx.
      busy_d  = (state_d != S_IDLE);
      ready_d = ena && (state_d == S_IDLE);
      done_d  = ena && (state_d == S_STOP) && (baud_d == BAUD_MAX);
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign ready      = ready_q;
   assign frame_done = done_q;

endmodule
